// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: FSM state encodings and
// the counter-width helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'b00,
        ST_WAIT_HIGH = 2'b01,
        ST_HIGH      = 2'b10,
        ST_WAIT_LOW  = 2'b11
    } state_t;

    // A one-bit counter is still needed when the threshold is tiny.
    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; clears to 0 on reset.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/x_input_debouncer.sv
// Debounces a raw pin into the clean serial bit x_out and produces one-cycle
// rise/fall strobes aligned with the x_out change.
module x_input_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic x_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic             sync;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             x_next;
    logic             x_out_reg, rise_reg, fall_reg;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_LOW;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        unique case (state_reg)
            ST_LOW: begin
                if (sync) state_next = ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: begin
                if (!sync) begin
                    state_next = ST_LOW;
                end else if (cnt_reg == CNT_LIMIT) begin
                    state_next = ST_HIGH;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!sync) state_next = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (sync) begin
                    state_next = ST_HIGH;
                end else if (cnt_reg == CNT_LIMIT) begin
                    state_next = ST_LOW;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = ST_LOW;
        endcase
    end

    // x_out is held in its own flop one cycle behind the state decode, so
    // the strobes can be formed from the decode and the current x_out.
    assign x_next = (state_reg == ST_HIGH) || (state_reg == ST_WAIT_LOW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_out_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            x_out_reg <= x_next;
            rise_reg  <= x_next & ~x_out_reg;
            fall_reg  <= ~x_next & x_out_reg;
        end
    end

    assign x_out      = x_out_reg;
    assign rise_pulse = rise_reg;
    assign fall_pulse = fall_reg;

endmodule

// File: tb/tb_x_input_debouncer.sv
// Scoreboard bench for x_input_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_x_input_debouncer;

    localparam int LAT = 7; // edge 0 is the next posedge; change visible after edge 6

    typedef struct {
        int cyc;
        bit is_rise;
    } event_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_in = 1'b1;
    logic x_out, rise_pulse, fall_pulse;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    event_t exp_q[$];

    x_input_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .x_out      (x_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_event(input bit is_rise);
        event_t e;
        e.cyc = cyc + LAT;
        e.is_rise = is_rise;
        exp_q.push_back(e);
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every strobe the DUT presents is matched against the queue.
    always @(negedge clk) begin
        if (!rst && (rise_pulse || fall_pulse)) begin
            checks++;
            if (rise_pulse && fall_pulse) begin
                errors++;
                $display("FAIL strobe_exclusive actual=both required=one cyc=%0d", cyc);
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=rise%b/fall%b required=none cyc=%0d",
                         rise_pulse, fall_pulse, cyc);
            end else begin
                event_t e;
                e = exp_q.pop_front();
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL strobe_cycle actual=%0d required=%0d", cyc, e.cyc);
                end
                check_bit("strobe_kind_rise", rise_pulse, e.is_rise);
                check_bit("x_out_at_strobe", x_out, e.is_rise);
                $display("event %s at cyc %0d (expected %0d)",
                         rise_pulse ? "rise" : "fall", cyc, e.cyc);
            end
        end
    end

    initial begin
        bit bounce [6];
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset held with raw_in high: outputs stay low.
        repeat (3) @(negedge clk);
        check_bit("reset_x_out", x_out, 1'b0);
        check_bit("reset_rise", rise_pulse, 1'b0);
        check_bit("reset_fall", fall_pulse, 1'b0);
        rst = 1'b0;
        expect_event(1'b1);
        repeat (12) @(negedge clk);

        // Clean fall then clean rise.
        raw_in = 1'b0;
        expect_event(1'b0);
        repeat (12) @(negedge clk);
        raw_in = 1'b1;
        expect_event(1'b1);
        repeat (12) @(negedge clk);
        raw_in = 1'b0;
        expect_event(1'b0);
        repeat (12) @(negedge clk);

        // Glitch: three high cycles are one short of the threshold.
        raw_in = 1'b1;
        repeat (3) @(negedge clk);
        raw_in = 1'b0;
        repeat (20) @(negedge clk);
        check_bit("glitch_x_out", x_out, 1'b0);

        // Bounce: only the final 0->1 starts a successful wait.
        for (int i = 0; i < 6; i++) begin
            raw_in = bounce[i];
            if (i == 5) expect_event(1'b1);
            @(negedge clk);
        end
        repeat (12) @(negedge clk);

        raw_in = 1'b0;
        expect_event(1'b0);
        repeat (12) @(negedge clk);

        // Reset in the middle of a rising wait restarts the full latency.
        raw_in = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_bit("midwait_x_out", x_out, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        expect_event(1'b1);
        repeat (12) @(negedge clk);

        // Asynchronous reset clears x_out without waiting for an edge.
        check_bit("pre_async_x_out", x_out, 1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_bit("async_reset_x_out", x_out, 1'b0);
        @(negedge clk);
        raw_in = 1'b0;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_bit("final_x_out", x_out, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes actual=%0d_pending required=0 next_cyc=%0d",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
